// File: rtl/icache_direct_mapped.sv
// ---------------------------------------------------------------------------------------------
// icache_direct_mapped
//
// Direct-mapped instruction cache between the CPU fetch stage and the instruction memory.
// The memory serves 16-byte blocks over a 28-bit block address. A hit returns the 32-bit
// instruction in the same cycle. A miss stalls the CPU, fetches the whole block and fills the
// line. The hit is then seen again from IDLE once the fill is done.
//
// Address split: offset = ADDRESS[3:2], index = ADDRESS[4 +: INDEX_BITS],
//                tag = ADDRESS[31 : 4+INDEX_BITS]
//
// Ports
//   CLK           in   1    system clock, rising edge
//   RESET_N       in   1    asynchronous active-low reset
//   READ          in   1    CPU fetch request (level)
//   ADDRESS       in   32   CPU byte address; bits [1:0] ignored
//   READDATA      out  32   instruction word (combinational, valid on hit)
//   BUSYWAIT      out  1    stall to the CPU (combinational)
//   MEM_READ      out  1    block read request to instruction memory (registered)
//   MEM_ADDRESS   out  28   block address to instruction memory (registered)
//   MEM_READDATA  in   128  block data, byte n at bits [8n+7:8n]
//   MEM_BUSYWAIT  in   1    instruction memory busy
//
// Optional feature (macro ICACHE_PERF_EN):
//   HIT_COUNT     out  32   saturating count of hits taken in IDLE
//   MISS_COUNT    out  32   saturating count of IDLE->FETCH transitions
// ---------------------------------------------------------------------------------------------
module icache_direct_mapped #(
  parameter int unsigned NUM_LINES  = 8,
  parameter int unsigned INDEX_BITS = 3,
  parameter int unsigned TAG_BITS   = 25
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          READ,
  input  logic [31:0]   ADDRESS,
  output logic [31:0]   READDATA,
  output logic          BUSYWAIT,
  output logic          MEM_READ,
  output logic [27:0]   MEM_ADDRESS,
  input  logic [127:0]  MEM_READDATA,
  input  logic          MEM_BUSYWAIT
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]   HIT_COUNT,
  output logic [31:0]   MISS_COUNT
`endif
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StFetch  = 2'd1,
    StUpdate = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  state_e                r_state;
  logic [NUM_LINES-1:0]  r_valid;
  logic [TAG_BITS-1:0]   r_tags [NUM_LINES];
  logic [127:0]          r_data [NUM_LINES];
  logic [127:0]          r_fill;
  logic                  r_seen_busy;
  logic                  r_mem_read;
  // Doubles as the latched miss address {tag, index} for the whole fill.
  logic [27:0]           r_mem_address;

  // ---------------------------------------------------------------------------
  // Address decode and hit detection
  // ---------------------------------------------------------------------------
  logic [1:0]            w_offset;
  logic [INDEX_BITS-1:0] w_index;
  logic [TAG_BITS-1:0]   w_tag;
  logic [127:0]          w_line;
  logic                  w_hit;
  logic [INDEX_BITS-1:0] w_upd_index;
  logic [TAG_BITS-1:0]   w_upd_tag;
  logic                  w_unused_addr;

  assign w_offset      = ADDRESS[3:2];
  assign w_index       = ADDRESS[4 +: INDEX_BITS];
  assign w_tag         = ADDRESS[31 -: TAG_BITS];
  assign w_unused_addr = ^ADDRESS[1:0];

  assign w_line = r_data[w_index];
  assign w_hit  = READ & r_valid[w_index] & (r_tags[w_index] == w_tag);

  assign w_upd_index = r_mem_address[INDEX_BITS-1:0];
  assign w_upd_tag   = r_mem_address[27 -: TAG_BITS];

  always_comb begin
    READDATA = w_line[{w_offset, 5'b00000} +: 32];
  end

  // Any non-IDLE state stalls a pending fetch, even if the current address would hit.
  assign BUSYWAIT    = READ & ((r_state != StIdle) | ~w_hit);
  assign MEM_READ    = r_mem_read;
  assign MEM_ADDRESS = r_mem_address;

  // ---------------------------------------------------------------------------
  // Control FSM with registered memory-side outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state       <= StIdle;
      r_valid       <= '0;
      r_seen_busy   <= 1'b0;
      r_fill        <= '0;
      r_mem_read    <= 1'b0;
      r_mem_address <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (READ && !w_hit) begin
            r_mem_address <= {w_tag, w_index};
            r_seen_busy   <= 1'b0;
            r_mem_read    <= 1'b1;
            r_state       <= StFetch;
          end
        end
        StFetch: begin
          // Data is only trusted after memory has acknowledged with at least one busy cycle.
          if (MEM_BUSYWAIT) begin
            r_seen_busy <= 1'b1;
          end else if (r_seen_busy) begin
            r_fill     <= MEM_READDATA;
            r_mem_read <= 1'b0;
            r_state    <= StUpdate;
          end
        end
        StUpdate: begin
          r_valid[w_upd_index] <= 1'b1;
          r_state              <= StIdle;
        end
        default: begin
          r_state    <= StIdle;
          r_mem_read <= 1'b0;
        end
      endcase
    end
  end

  // Tag and data arrays carry no reset; the valid bits guard them.
  always_ff @(posedge CLK) begin
    if (r_state == StUpdate) begin
      r_tags[w_upd_index] <= w_upd_tag;
      r_data[w_upd_index] <= r_fill;
    end
  end

`ifdef ICACHE_PERF_EN
  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else if (r_state == StIdle) begin
      if (w_hit && (r_hit_count != 32'hFFFF_FFFF)) begin
        r_hit_count <= r_hit_count + 32'd1;
      end
      if (READ && !w_hit && (r_miss_count != 32'hFFFF_FFFF)) begin
        r_miss_count <= r_miss_count + 32'd1;
      end
    end
  end

  assign HIT_COUNT  = r_hit_count;
  assign MISS_COUNT = r_miss_count;
`endif

endmodule

// File: tb/tb_icache_direct_mapped.sv
// ---------------------------------------------------------------------------------------------
// tb_icache_direct_mapped
//
// Self-checking bench for icache_direct_mapped. A behavioural block memory answers requests
// after ten busy cycles; block b holds bytes (16*b + n) & 0xFF. Expected block addresses are
// queued when a miss is provoked and popped by a monitor when MEM_READ rises.
// ---------------------------------------------------------------------------------------------
module tb_icache_direct_mapped;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          READ = 1'b0;
  logic [31:0]   ADDRESS = '0;
  logic [31:0]   READDATA;
  logic          BUSYWAIT;
  logic          MEM_READ;
  logic [27:0]   MEM_ADDRESS;
  logic [127:0]  MEM_READDATA;
  logic          MEM_BUSYWAIT;
`ifdef ICACHE_PERF_EN
  logic [31:0]   HIT_COUNT;
  logic [31:0]   MISS_COUNT;
`endif

  icache_direct_mapped #(
    .NUM_LINES  (8),
    .INDEX_BITS (3),
    .TAG_BITS   (25)
  ) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .READ         (READ),
    .ADDRESS      (ADDRESS),
    .READDATA     (READDATA),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
`ifdef ICACHE_PERF_EN
    ,
    .HIT_COUNT    (HIT_COUNT),
    .MISS_COUNT   (MISS_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // ---------------------------------------------------------------------------
  // Instruction memory model
  // ---------------------------------------------------------------------------
  localparam int unsigned MemLat = 10;
  logic        mem_busy;
  logic        mem_active;
  int unsigned mem_cnt;

  assign MEM_BUSYWAIT = mem_busy;

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      mem_busy   <= 1'b0;
      mem_active <= 1'b0;
      mem_cnt    <= 0;
    end else if (MEM_READ && !mem_active) begin
      mem_active <= 1'b1;
      mem_busy   <= 1'b1;
      mem_cnt    <= MemLat - 1;
    end else if (mem_busy) begin
      if (mem_cnt == 0) mem_busy <= 1'b0;
      else              mem_cnt  <= mem_cnt - 1;
    end else if (!MEM_READ) begin
      mem_active <= 1'b0;
    end
  end

  always_comb begin
    MEM_READDATA = '0;
    for (int n = 0; n < 16; n++) begin
      MEM_READDATA[8*n +: 8] = {MEM_ADDRESS[3:0], 4'b0000} + 8'(n);
    end
  end

  // ---------------------------------------------------------------------------
  // Request scoreboard
  // ---------------------------------------------------------------------------
  logic [27:0] exp_q[$];
  logic [27:0] exp_addr;
  int          req_count = 0;
  logic        prev_mr = 1'b0;

  always @(negedge CLK) begin
    if (MEM_READ && !prev_mr) begin
      req_count++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL mem_req_unexpected: got MEM_ADDRESS=%h, required no request", MEM_ADDRESS);
      end else begin
        exp_addr = exp_q.pop_front();
        if (MEM_ADDRESS !== exp_addr) begin
          failures++;
          $display("FAIL mem_req_addr: got MEM_ADDRESS=%h, required %h", MEM_ADDRESS, exp_addr);
        end
      end
    end
    prev_mr <= MEM_READ;
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic wait_ready(input string name, input int unsigned budget);
    int unsigned n = 0;
    while (BUSYWAIT && n < budget) begin
      @(negedge CLK);
      #1;
      n++;
    end
    check(name, 32'(BUSYWAIT), 32'd0);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          miss;
    logic [27:0] mem_addr;
  } vec_t;

  task automatic do_fetch(input vec_t v);
    int req0;
    @(negedge CLK);
    READ    = 1'b1;
    ADDRESS = v.addr;
    #1;
    if (v.miss) begin
      exp_q.push_back(v.mem_addr);
      req0 = req_count;
      check("miss_busywait", 32'(BUSYWAIT), 32'd1);
      @(negedge CLK);
      #1;
      check("miss_mem_read", 32'(MEM_READ), 32'd1);
      wait_ready("miss_fill_timeout", 200);
      check("miss_req_count", 32'(req_count - req0), 32'd1);
    end else begin
      check("hit_busywait", 32'(BUSYWAIT), 32'd0);
      check("hit_mem_read", 32'(MEM_READ), 32'd0);
    end
    check("readdata", READDATA, v.data);
  endtask

  vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Cold fill, hits in the line, conflict eviction of line 0 and back.
    vecs[0] = '{32'h0000_0000, 32'h0302_0100, 1'b1, 28'h000_0000};
    vecs[1] = '{32'h0000_0004, 32'h0706_0504, 1'b0, 28'h000_0000};
    vecs[2] = '{32'h0000_0008, 32'h0B0A_0908, 1'b0, 28'h000_0000};
    vecs[3] = '{32'h0000_000C, 32'h0F0E_0D0C, 1'b0, 28'h000_0000};
    vecs[4] = '{32'h0000_0080, 32'h8382_8180, 1'b1, 28'h000_0008};
    vecs[5] = '{32'h0000_0084, 32'h8786_8584, 1'b0, 28'h000_0000};
    vecs[6] = '{32'h0000_0000, 32'h0302_0100, 1'b1, 28'h000_0000};
    vecs[7] = '{32'h0000_000C, 32'h0F0E_0D0C, 1'b0, 28'h000_0000};

    // Reset state
    repeat (2) @(negedge CLK);
    #1;
    check("reset_busywait", 32'(BUSYWAIT), 32'd0);
    check("reset_mem_read", 32'(MEM_READ), 32'd0);
    check("reset_mem_address", 32'(MEM_ADDRESS), 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;

    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        @(negedge CLK);
        READ = 1'b0;
        #1;
        check("idle_busywait", 32'(BUSYWAIT), 32'd0);
`ifdef ICACHE_PERF_EN
        check("perf_miss_count", MISS_COUNT, 32'd1);
        check("perf_hit_count", HIT_COUNT, 32'd4);
`endif
      end
      do_fetch(vecs[i]);
    end

    // Address change during FETCH: the fill finishes for block 1, then block 2 misses.
    @(negedge CLK);
    READ    = 1'b1;
    ADDRESS = 32'h0000_0010;
    exp_q.push_back(28'h000_0001);
    exp_q.push_back(28'h000_0002);
    repeat (3) @(negedge CLK);
    ADDRESS = 32'h0000_0020;
    #1;
    check("midchg_busywait", 32'(BUSYWAIT), 32'd1);
    check("midchg_mem_address", 32'(MEM_ADDRESS), 32'h1);
    wait_ready("midchg_fill_timeout", 300);
    check("midchg_readdata", READDATA, 32'h2322_2120);
    do_fetch('{32'h0000_0010, 32'h1312_1110, 1'b0, 28'h000_0000});

    // Reset in the middle of a fetch.
    @(negedge CLK);
    READ    = 1'b1;
    ADDRESS = 32'h0000_0030;
    exp_q.push_back(28'h000_0003);
    repeat (4) @(negedge CLK);
    #1;
    check("prerst_mem_read", 32'(MEM_READ), 32'd1);
    RESET_N = 1'b0;
    READ    = 1'b0;
    #1;
    check("rst_mem_read", 32'(MEM_READ), 32'd0);
    check("rst_busywait", 32'(BUSYWAIT), 32'd0);
    check("rst_mem_address", 32'(MEM_ADDRESS), 32'd0);
`ifdef ICACHE_PERF_EN
    check("rst_hit_count", HIT_COUNT, 32'd0);
    check("rst_miss_count", MISS_COUNT, 32'd0);
`endif
    @(negedge CLK);
    RESET_N = 1'b1;
    // Line 0 held block 0 before reset; it must miss now.
    do_fetch('{32'h0000_000C, 32'h0F0E_0D0C, 1'b1, 28'h000_0000});

    @(negedge CLK);
    READ = 1'b0;
    #1;
    check("final_busywait", 32'(BUSYWAIT), 32'd0);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_req_total", 32'(req_count), 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache_direct_mapped.md
Name: icache_direct_mapped

Overview:
- Direct-mapped instruction cache between the CPU fetch stage and the block-based instruction memory.
- The instruction memory serves 16-byte blocks over a 28-bit block address, with a 128-bit data bus and a BUSYWAIT handshake.
- On a hit this cache returns a 32-bit instruction in the same cycle.
- On a miss it stalls the CPU, fetches the whole block from instruction memory and fills the line.

Parameters:
- NUM_LINES, 8, number of cache lines; power of two, at least 2.
- INDEX_BITS, 3, log2(NUM_LINES).
- TAG_BITS, 25, equals 28 - INDEX_BITS.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- READ  in  1  CPU fetch request (level).
- ADDRESS  in  32  CPU byte address (PC); bits [1:0] are ignored.
- READDATA  out  32  instruction word.
- BUSYWAIT  out  1  stall to the CPU.
- MEM_READ  out  1  block read request to instruction memory.
- MEM_ADDRESS  out  28  block address to instruction memory.
- MEM_READDATA  in  128  block data; byte n sits at bits [8n+7:8n].
- MEM_BUSYWAIT  in  1  instruction memory busy.

Behaviour:
- Address split:
  - offset = ADDRESS[3:2]
  - index = ADDRESS[4+INDEX_BITS-1:4]
  - tag = ADDRESS[31:4+INDEX_BITS]
- Storage per line: valid bit, TAG_BITS tag, 128-bit data.
- hit = READ & valid[index] & (tag_store[index] == tag). Combinational.
- READDATA = line[index] word[offset], where word k = bits [32k+31:32k]. Combinational; its value is don't-care when there is no hit.
- BUSYWAIT = READ & (state != IDLE | !hit). Combinational. BUSYWAIT = 0 whenever READ = 0 and state = IDLE.
- FSM states: IDLE, FETCH, UPDATE.
  - IDLE: if READ & !hit at a posedge, latch {tag,index} into miss_addr, clear seen_busy, go to FETCH.
  - FETCH:
    - MEM_READ = 1, MEM_ADDRESS = miss_addr.
    - Set seen_busy at any posedge where MEM_BUSYWAIT = 1.
    - At a posedge where seen_busy = 1 and MEM_BUSYWAIT = 0: capture MEM_READDATA into a fill register and go to UPDATE.
  - UPDATE:
    - MEM_READ = 0.
    - Write the fill register, tag and valid = 1 into line miss_addr[INDEX_BITS-1:0].
    - Go to IDLE.
- In IDLE the current ADDRESS is re-evaluated, so the hit appears one cycle after UPDATE.
- Miss latency: 1 (IDLE→FETCH) + memory time + 1 (UPDATE) + hit cycle.
- ADDRESS or READ changing during FETCH: ignored. The fill completes using miss_addr and the result is not forwarded. If READ has dropped, the filled line still becomes valid.
- Outside FETCH: MEM_READ = 0. MEM_ADDRESS holds its last value.
- Reset, including mid-FETCH:
  - All valid bits cleared.
  - state = IDLE, MEM_READ = 0, MEM_ADDRESS = 0, seen_busy = 0, fill register = 0.
  - Tag and data arrays are not reset.
- Simultaneous events: a hit on a line being filled in UPDATE is impossible, since BUSYWAIT = 1 in that state.

Optional Feature:
- Macro: ICACHE_PERF_EN.
- Defined:
  - Adds output ports HIT_COUNT[31:0] and MISS_COUNT[31:0], both reset to 0.
  - HIT_COUNT increments at a posedge in IDLE with READ & hit.
  - MISS_COUNT increments on each IDLE→FETCH transition.
  - Both counters saturate at 0xFFFFFFFF.
- Not defined: neither port exists and no counter logic is generated.

Test Plan:
- Cold miss: release reset, READ = 1, ADDRESS = 0x00000000, memory model with BUSYWAIT high for 10 cycles holding block 0 bytes 0x00..0x0F.
  - Required: BUSYWAIT = 1, MEM_READ = 1, MEM_ADDRESS = 0.
  - After the fill, READDATA = 0x03020100 and BUSYWAIT = 0.
- Hits within the line: after the cold fill, ADDRESS = 0x4, 0x8, 0xC in consecutive cycles.
  - Required: READDATA = 0x07060504, 0x0B0A0908, 0x0F0E0D0C; BUSYWAIT = 0 throughout; MEM_READ is never asserted.
- Conflict eviction: fetch 0x00, then 0x80 (same index, different tag), then 0x00 again.
  - Required: three misses, MEM_ADDRESS = 0x0000000, 0x0000008, 0x0000000.
- Mid-miss address change: miss on 0x10, change ADDRESS to 0x20 during FETCH.
  - Required: the fill uses MEM_ADDRESS = 0x1, then a second miss with MEM_ADDRESS = 0x2; line 1 is valid afterwards.
- Reset during FETCH: assert RESET_N = 0 mid-fetch.
  - Required: MEM_READ drops immediately and BUSYWAIT = 0 with READ = 0.
  - A re-fetch of a previously cached address misses.
- ICACHE_PERF_EN defined: run the cold-miss plus hits-within-the-line sequence.
  - Required: MISS_COUNT = 1, HIT_COUNT = 4.
